// File: rtl/pipeline_pkg.sv
// +----------------------------------------------------------------------+
// | Module   : pipeline_pkg                                              |
// | Purpose  : Shared types for the ID/EX stage: ALU opcodes, forward    |
// |            select codes, the held-instruction record and helpers.    |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

package pipeline_pkg;

  localparam int IDEX_DW = 32;
  localparam int IDEX_AW = 5;

  // Register x0 is hard-wired to zero and never produces a dependency.
  localparam logic [IDEX_AW-1:0] REG_ZERO = '0;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'b0000,
    ALU_SUB  = 4'b0001,
    ALU_AND  = 4'b0010,
    ALU_OR   = 4'b0011,
    ALU_XOR  = 4'b0100,
    ALU_SLT  = 4'b0101,
    ALU_SLTU = 4'b0110,
    ALU_SRL  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_LUI  = 4'b1001,
    ALU_SLL  = 4'b1010
  } alu_op_e;

  typedef enum logic [1:0] {
    FWD_HELD = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } fwd_sel_e;

  typedef struct packed {
    alu_op_e                ctrl;
    logic [IDEX_AW-1:0]     rs1;
    logic [IDEX_AW-1:0]     rs2;
    logic [IDEX_AW-1:0]     rd;
    logic                   reg_write;
    logic [IDEX_DW-1:0]     rd1;
    logic [IDEX_DW-1:0]     rd2;
    logic [IDEX_DW-1:0]     imm;
    logic [IDEX_DW-1:0]     pc;
    logic                   src_a_pc;
    logic                   src_b_imm;
  } idex_t;

  // True when a writing producer targets a non-zero source register.
  function automatic logic rs_match(input logic [IDEX_AW-1:0] rs,
                                    input logic               we,
                                    input logic [IDEX_AW-1:0] rd);
    return we && (rd == rs) && (rs != REG_ZERO);
  endfunction

endpackage

`default_nettype wire

// File: rtl/id_ex_stage_if.sv
// +----------------------------------------------------------------------+
// | Module   : id_ex_stage_if                                            |
// | Purpose  : Decode-to-ID/EX bus: valid/ready handshake plus the       |
// |            decoded instruction fields and regfile read data.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

interface id_ex_stage_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [3:0]            in_alu_ctrl;
  logic [REG_ADDR_W-1:0] in_rs1;
  logic [REG_ADDR_W-1:0] in_rs2;
  logic [REG_ADDR_W-1:0] in_rd;
  logic                  in_reg_write;
  logic [DATA_WIDTH-1:0] in_rd1;
  logic [DATA_WIDTH-1:0] in_rd2;
  logic [DATA_WIDTH-1:0] in_imm;
  logic [DATA_WIDTH-1:0] in_pc;
  logic                  in_src_a_pc;
  logic                  in_src_b_imm;

  // Decode side drives the instruction, the stage answers with ready.
  modport master (
    output in_valid, in_alu_ctrl, in_rs1, in_rs2, in_rd, in_reg_write,
           in_rd1, in_rd2, in_imm, in_pc, in_src_a_pc, in_src_b_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_alu_ctrl, in_rs1, in_rs2, in_rd, in_reg_write,
           in_rd1, in_rd2, in_imm, in_pc, in_src_a_pc, in_src_b_imm,
    output in_ready
  );
endinterface

`default_nettype wire

// File: rtl/forward_unit.sv
// +----------------------------------------------------------------------+
// | Module   : forward_unit                                              |
// | Purpose  : Compares two source registers against EX/MEM/WB producers |
// |            and reports a forward select per operand plus a RAW flag. |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module forward_unit
  import pipeline_pkg::*;
(
  input  wire logic [IDEX_AW-1:0] rs1,
  input  wire logic [IDEX_AW-1:0] rs2,
  input  wire logic               use_rs1,
  input  wire logic               use_rs2,
  input  wire logic               ex_valid,
  input  wire logic               ex_reg_write,
  input  wire logic [IDEX_AW-1:0] ex_rd,
  input  wire logic               mem_reg_write,
  input  wire logic [IDEX_AW-1:0] mem_rd,
  input  wire logic               wb_reg_write,
  input  wire logic [IDEX_AW-1:0] wb_rd,
  output fwd_sel_e                fwd_a,
  output fwd_sel_e                fwd_b,
  output logic                    hazard
);

  logic hz_a;
  logic hz_b;

  // Forward select per operand; the younger MEM producer beats WB.
  always_comb begin
    fwd_a = FWD_HELD;
    fwd_b = FWD_HELD;
    if (use_rs1 && rs_match(rs1, mem_reg_write, mem_rd))     fwd_a = FWD_MEM;
    else if (use_rs1 && rs_match(rs1, wb_reg_write, wb_rd))  fwd_a = FWD_WB;
    if (use_rs2 && rs_match(rs2, mem_reg_write, mem_rd))     fwd_b = FWD_MEM;
    else if (use_rs2 && rs_match(rs2, wb_reg_write, wb_rd))  fwd_b = FWD_WB;
  end

  assign hz_a = use_rs1 && (rs_match(rs1, ex_valid && ex_reg_write, ex_rd) ||
                            rs_match(rs1, mem_reg_write, mem_rd) ||
                            rs_match(rs1, wb_reg_write, wb_rd));
  assign hz_b = use_rs2 && (rs_match(rs2, ex_valid && ex_reg_write, ex_rd) ||
                            rs_match(rs2, mem_reg_write, mem_rd) ||
                            rs_match(rs2, wb_reg_write, wb_rd));
  assign hazard = hz_a || hz_b;

endmodule

`default_nettype wire

// File: rtl/id_ex_stage.sv
// +----------------------------------------------------------------------+
// | Module   : id_ex_stage                                               |
// | Purpose  : ID/EX pipeline register feeding the ALU. Holds one        |
// |            decoded instruction, muxes PC/imm operands, resolves EX   |
// |            data hazards and handles valid/ready stall and flush.     |
// | Config   : IDEX_FORWARD_EN - forward MEM/WB results to operands;     |
// |            when undefined, RAW hazards stall decode instead.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module id_ex_stage
  import pipeline_pkg::*;
#(
  parameter int DATA_WIDTH = IDEX_DW,
  parameter int REG_ADDR_W = IDEX_AW
) (
  input  wire logic                  clk,
  input  wire logic                  rst_n,
  id_ex_stage_if.slave               dec,
  input  wire logic                  flush,
  input  wire logic                  ex_ready,
  input  wire logic                  mem_reg_write,
  input  wire logic [REG_ADDR_W-1:0] mem_rd,
  input  wire logic [DATA_WIDTH-1:0] mem_result,
  input  wire logic                  wb_reg_write,
  input  wire logic [REG_ADDR_W-1:0] wb_rd,
  input  wire logic [DATA_WIDTH-1:0] wb_result,
  output logic                       ex_valid,
  output logic [3:0]                 ALUControl,
  output logic [DATA_WIDTH-1:0]      SrcA,
  output logic [DATA_WIDTH-1:0]      SrcB,
  output logic [REG_ADDR_W-1:0]      ex_rd,
  output logic                       ex_reg_write,
  output logic                       haz_stall
);

  idex_t                 held;
  idex_t                 incoming;
  logic                  load;
  logic [DATA_WIDTH-1:0] opa_reg;
  logic [DATA_WIDTH-1:0] opb_reg;

  assign incoming = '{ctrl:      alu_op_e'(dec.in_alu_ctrl),
                      rs1:       dec.in_rs1,
                      rs2:       dec.in_rs2,
                      rd:        dec.in_rd,
                      reg_write: dec.in_reg_write,
                      rd1:       dec.in_rd1,
                      rd2:       dec.in_rd2,
                      imm:       dec.in_imm,
                      pc:        dec.in_pc,
                      src_a_pc:  dec.in_src_a_pc,
                      src_b_imm: dec.in_src_b_imm};

  assign dec.in_ready = (!ex_valid || ex_ready) && !haz_stall;
  assign load         = dec.in_valid && dec.in_ready;

`ifdef IDEX_FORWARD_EN
  fwd_sel_e fwd_a;
  fwd_sel_e fwd_b;
  logic     unused_hazard;

  // The held instruction is the consumer; EX has no older producer here.
  forward_unit u_forward_unit (
    .rs1           (held.rs1),
    .rs2           (held.rs2),
    .use_rs1       (!held.src_a_pc),
    .use_rs2       (!held.src_b_imm),
    .ex_valid      (1'b0),
    .ex_reg_write  (1'b0),
    .ex_rd         (REG_ZERO),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_a         (fwd_a),
    .fwd_b         (fwd_b),
    .hazard        (unused_hazard)
  );

  // Pick the freshest value for each register-sourced operand.
  always_comb begin
    opa_reg = held.rd1;
    opb_reg = held.rd2;
    case (fwd_a)
      FWD_MEM: opa_reg = mem_result;
      FWD_WB:  opa_reg = wb_result;
      default: opa_reg = held.rd1;
    endcase
    case (fwd_b)
      FWD_MEM: opb_reg = mem_result;
      FWD_WB:  opb_reg = wb_result;
      default: opb_reg = held.rd2;
    endcase
  end

  assign haz_stall = 1'b0;
`else
  fwd_sel_e unused_fwd_a;
  fwd_sel_e unused_fwd_b;
  logic     hazard;
  logic     unused_bits;

  // The incoming instruction is the consumer; any in-flight writer stalls it.
  forward_unit u_forward_unit (
    .rs1           (dec.in_rs1),
    .rs2           (dec.in_rs2),
    .use_rs1       (!dec.in_src_a_pc),
    .use_rs2       (!dec.in_src_b_imm),
    .ex_valid      (ex_valid),
    .ex_reg_write  (held.reg_write),
    .ex_rd         (held.rd),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .fwd_a         (unused_fwd_a),
    .fwd_b         (unused_fwd_b),
    .hazard        (hazard)
  );

  assign opa_reg     = held.rd1;
  assign opb_reg     = held.rd2;
  assign haz_stall   = dec.in_valid && hazard;
  assign unused_bits = ^{mem_result, wb_result, held.rs1, held.rs2};
`endif

  // Valid bit and held instruction; flush kills, stalled entries keep forwarded data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid <= 1'b0;
      held     <= '0;
    end else begin
      if (flush)          ex_valid <= 1'b0;
      else if (load)      ex_valid <= 1'b1;
      else if (ex_ready)  ex_valid <= 1'b0;

      if (load && !flush) begin
        held <= incoming;
      end else if (ex_valid && !ex_ready) begin
        // Capture forwarded values so they survive the producer retiring.
        held.rd1 <= opa_reg;
        held.rd2 <= opb_reg;
      end
    end
  end

  assign ALUControl   = held.ctrl;
  assign SrcA         = held.src_a_pc  ? held.pc  : opa_reg;
  assign SrcB         = held.src_b_imm ? held.imm : opb_reg;
  assign ex_rd        = held.rd;
  assign ex_reg_write = held.reg_write;

endmodule

`default_nettype wire

// File: tb/tb_id_ex_stage.sv
// +----------------------------------------------------------------------+
// | Module   : tb_id_ex_stage                                            |
// | Purpose  : Directed self-checking bench for id_ex_stage.             |
// | Config   : IDEX_FORWARD_EN selects the forwarding scenarios.         |
// | Revision : 1.0  initial release                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic        ex_ready;
  logic        mem_reg_write;
  logic [4:0]  mem_rd;
  logic [31:0] mem_result;
  logic        wb_reg_write;
  logic [4:0]  wb_rd;
  logic [31:0] wb_result;
  logic        ex_valid;
  logic [3:0]  ALUControl;
  logic [31:0] SrcA;
  logic [31:0] SrcB;
  logic [4:0]  ex_rd;
  logic        ex_reg_write;
  logic        haz_stall;

  int errors = 0;
  int checks = 0;

  id_ex_stage_if #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dec_if ();

  id_ex_stage #(.DATA_WIDTH(32), .REG_ADDR_W(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .dec           (dec_if),
    .flush         (flush),
    .ex_ready      (ex_ready),
    .mem_reg_write (mem_reg_write),
    .mem_rd        (mem_rd),
    .mem_result    (mem_result),
    .wb_reg_write  (wb_reg_write),
    .wb_rd         (wb_rd),
    .wb_result     (wb_result),
    .ex_valid      (ex_valid),
    .ALUControl    (ALUControl),
    .SrcA          (SrcA),
    .SrcB          (SrcB),
    .ex_rd         (ex_rd),
    .ex_reg_write  (ex_reg_write),
    .haz_stall     (haz_stall)
  );

  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] ctrl, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [4:0] rd, input logic rw, input logic [31:0] rd1,
                       input logic [31:0] rd2, input logic [31:0] imm, input logic [31:0] pc,
                       input logic sa, input logic sb);
    dec_if.in_alu_ctrl  = ctrl;
    dec_if.in_rs1       = rs1;
    dec_if.in_rs2       = rs2;
    dec_if.in_rd        = rd;
    dec_if.in_reg_write = rw;
    dec_if.in_rd1       = rd1;
    dec_if.in_rd2       = rd2;
    dec_if.in_imm       = imm;
    dec_if.in_pc        = pc;
    dec_if.in_src_a_pc  = sa;
    dec_if.in_src_b_imm = sb;
  endtask

  task automatic idle();
    dec_if.in_valid = 1'b0;
    flush = 1'b0; ex_ready = 1'b1;
    mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
    wb_reg_write = 1'b0;  wb_rd = 5'd0;  wb_result = 32'd0;
    step();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    dec_if.in_valid = 1'b0;
    drive(4'h0, 5'd0, 5'd0, 5'd0, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    flush = 1'b0; ex_ready = 1'b1;
    mem_reg_write = 1'b0; mem_rd = 5'd0; mem_result = 32'd0;
    wb_reg_write = 1'b0;  wb_rd = 5'd0;  wb_result = 32'd0;
    #2;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", ex_valid); end
    checks++; if (ALUControl !== 4'h0) begin errors++; $display("FAIL reset_ctrl got=%h exp=0", ALUControl); end
    checks++; if (SrcA !== 32'd0) begin errors++; $display("FAIL reset_srca got=%h exp=0", SrcA); end
    checks++; if (SrcB !== 32'd0) begin errors++; $display("FAIL reset_srcb got=%h exp=0", SrcB); end
    checks++; if (ex_rd !== 5'd0) begin errors++; $display("FAIL reset_rd got=%h exp=0", ex_rd); end
    checks++; if (ex_reg_write !== 1'b0) begin errors++; $display("FAIL reset_rw got=%b exp=0", ex_reg_write); end
    checks++; if (dec_if.in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", dec_if.in_ready); end
    step(); step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_basic_add();
    drive(4'h0, 5'd1, 5'd2, 5'd5, 1'b1, 32'd5, 32'd7, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1; ex_ready = 1'b1;
    #1;
    checks++; if (dec_if.in_ready !== 1'b1) begin errors++; $display("FAIL add_ready got=%b exp=1", dec_if.in_ready); end
    step();
    dec_if.in_valid = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL add_valid got=%b exp=1", ex_valid); end
    checks++; if (ALUControl !== 4'h0) begin errors++; $display("FAIL add_ctrl got=%h exp=0", ALUControl); end
    checks++; if (SrcA !== 32'd5) begin errors++; $display("FAIL add_srca got=%h exp=5", SrcA); end
    checks++; if (SrcB !== 32'd7) begin errors++; $display("FAIL add_srcb got=%h exp=7", SrcB); end
    checks++; if (ex_rd !== 5'd5 || ex_reg_write !== 1'b1) begin errors++; $display("FAIL add_dest got=%h/%b exp=05/1", ex_rd, ex_reg_write); end
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL add_drain got=%b exp=0", ex_valid); end
  endtask

  task automatic test_mux();
    drive(4'h1, 5'd3, 5'd4, 5'd6, 1'b0, 32'h33, 32'h44, 32'hFFFF_FFFC, 32'h100, 1'b1, 1'b1);
    dec_if.in_valid = 1'b1;
    step();
    dec_if.in_valid = 1'b0;
    #1;
    checks++; if (SrcA !== 32'h100) begin errors++; $display("FAIL mux_srca got=%h exp=00000100", SrcA); end
    checks++; if (SrcB !== 32'hFFFF_FFFC) begin errors++; $display("FAIL mux_srcb got=%h exp=fffffffc", SrcB); end
    checks++; if (ALUControl !== 4'h1) begin errors++; $display("FAIL mux_ctrl got=%h exp=1", ALUControl); end
    idle();
  endtask

  task automatic test_back_to_back();
    drive(4'h0, 5'd1, 5'd2, 5'd6, 1'b1, 32'd1, 32'd2, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1; ex_ready = 1'b1;
    step();
    drive(4'hA, 5'd7, 5'd8, 5'd9, 1'b1, 32'd10, 32'd20, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checks++; if (SrcA !== 32'd1) begin errors++; $display("FAIL b2b_first_srca got=%h exp=1", SrcA); end
    checks++; if (dec_if.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready got=%b exp=1", dec_if.in_ready); end
    step();
    dec_if.in_valid = 1'b0;
    #1;
    checks++; if (SrcA !== 32'd10 || SrcB !== 32'd20) begin errors++; $display("FAIL b2b_second_ops got=%h/%h exp=a/14", SrcA, SrcB); end
    checks++; if (ALUControl !== 4'hA || ex_valid !== 1'b1) begin errors++; $display("FAIL b2b_second_ctrl got=%h/%b exp=a/1", ALUControl, ex_valid); end
    idle();
  endtask

  task automatic test_stall();
    drive(4'h0, 5'd1, 5'd2, 5'd10, 1'b1, 32'hA1, 32'hA2, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1; ex_ready = 1'b0;
    step();
    drive(4'h2, 5'd11, 5'd12, 5'd13, 1'b0, 32'hB1, 32'hB2, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checks++; if (dec_if.in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b exp=0", dec_if.in_ready); end
    step();
    checks++; if (SrcA !== 32'hA1 || ex_valid !== 1'b1) begin errors++; $display("FAIL stall_hold got=%h/%b exp=a1/1", SrcA, ex_valid); end
    ex_ready = 1'b1;
    #1;
    checks++; if (dec_if.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", dec_if.in_ready); end
    step();
    dec_if.in_valid = 1'b0;
    #1;
    checks++; if (SrcA !== 32'hB1 || ALUControl !== 4'h2) begin errors++; $display("FAIL stall_next got=%h/%h exp=b1/2", SrcA, ALUControl); end
    idle();
  endtask

  task automatic test_flush();
    drive(4'h3, 5'd1, 5'd2, 5'd14, 1'b1, 32'h44, 32'h45, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1; flush = 1'b1; ex_ready = 1'b1;
    #1;
    checks++; if (dec_if.in_ready !== 1'b1) begin errors++; $display("FAIL flush_ready got=%b exp=1", dec_if.in_ready); end
    step();
    dec_if.in_valid = 1'b0; flush = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_load got=%b exp=0", ex_valid); end
    dec_if.in_valid = 1'b1; ex_ready = 1'b0;
    step();
    dec_if.in_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL flush_preload got=%b exp=1", ex_valid); end
    flush = 1'b1;
    step();
    flush = 1'b0;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_held got=%b exp=0", ex_valid); end
    idle();
  endtask

`ifndef IDEX_FORWARD_EN
  task automatic test_hazard_stall();
    // Producer writes x4 and is held in EX.
    drive(4'h0, 5'd1, 5'd2, 5'd4, 1'b1, 32'h1, 32'h2, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1; ex_ready = 1'b0;
    step();
    // Consumer reads x4 through rs2.
    drive(4'h0, 5'd0, 5'd4, 5'd9, 1'b1, 32'h0, 32'h77, 32'd0, 32'd0, 1'b0, 1'b0);
    #1;
    checks++; if (haz_stall !== 1'b1 || dec_if.in_ready !== 1'b0) begin errors++; $display("FAIL haz_ex got=%b/%b exp=1/0", haz_stall, dec_if.in_ready); end
    ex_ready = 1'b1;
    step();
    mem_reg_write = 1'b1; mem_rd = 5'd4;
    #1;
    checks++; if (haz_stall !== 1'b1 || ex_valid !== 1'b0) begin errors++; $display("FAIL haz_mem got=%b/%b exp=1/0", haz_stall, ex_valid); end
    step();
    mem_reg_write = 1'b0; wb_reg_write = 1'b1; wb_rd = 5'd4;
    #1;
    checks++; if (haz_stall !== 1'b1 || dec_if.in_ready !== 1'b0) begin errors++; $display("FAIL haz_wb got=%b/%b exp=1/0", haz_stall, dec_if.in_ready); end
    step();
    wb_reg_write = 1'b0;
    #1;
    checks++; if (haz_stall !== 1'b0 || dec_if.in_ready !== 1'b1) begin errors++; $display("FAIL haz_clear got=%b/%b exp=0/1", haz_stall, dec_if.in_ready); end
    step();
    dec_if.in_valid = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b1 || SrcB !== 32'h77 || ex_rd !== 5'd9) begin errors++; $display("FAIL haz_load got=%b/%h/%h exp=1/77/9", ex_valid, SrcB, ex_rd); end
    idle();
    // x0 and immediate-sourced operands never stall.
    mem_reg_write = 1'b1; mem_rd = 5'd0;
    drive(4'h0, 5'd0, 5'd0, 5'd1, 1'b1, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1;
    #1;
    checks++; if (haz_stall !== 1'b0) begin errors++; $display("FAIL haz_x0 got=%b exp=0", haz_stall); end
    mem_rd = 5'd4;
    drive(4'h0, 5'd0, 5'd4, 5'd1, 1'b1, 32'h0, 32'h0, 32'h8, 32'd0, 1'b0, 1'b1);
    #1;
    checks++; if (haz_stall !== 1'b0) begin errors++; $display("FAIL haz_imm got=%b exp=0", haz_stall); end
    idle();
  endtask
`else
  task automatic test_forward();
    drive(4'h0, 5'd3, 5'd0, 5'd8, 1'b1, 32'h33, 32'h2, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1; ex_ready = 1'b0;
    step();
    dec_if.in_valid = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'hAA;
    wb_reg_write = 1'b1;  wb_rd = 5'd3;  wb_result = 32'hBB;
    #1;
    checks++; if (SrcA !== 32'hAA) begin errors++; $display("FAIL fwd_mem_wins got=%h exp=aa", SrcA); end
    checks++; if (haz_stall !== 1'b0) begin errors++; $display("FAIL fwd_no_stall got=%b exp=0", haz_stall); end
    mem_reg_write = 1'b0;
    #1;
    checks++; if (SrcA !== 32'hBB) begin errors++; $display("FAIL fwd_wb got=%h exp=bb", SrcA); end
    wb_reg_write = 1'b0;
    #1;
    checks++; if (SrcA !== 32'h33) begin errors++; $display("FAIL fwd_none got=%h exp=33", SrcA); end
    idle();
    drive(4'h0, 5'd0, 5'd0, 5'd8, 1'b1, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1;
    step();
    dec_if.in_valid = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd0; mem_result = 32'h55;
    #1;
    checks++; if (SrcA !== 32'h0) begin errors++; $display("FAIL fwd_x0 got=%h exp=0", SrcA); end
    idle();
  endtask

  task automatic test_fwd_hold();
    drive(4'h0, 5'd3, 5'd0, 5'd8, 1'b1, 32'h0, 32'h0, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1; ex_ready = 1'b0;
    step();
    dec_if.in_valid = 1'b0;
    mem_reg_write = 1'b1; mem_rd = 5'd3; mem_result = 32'h11;
    #1;
    checks++; if (SrcA !== 32'h11) begin errors++; $display("FAIL hold_mem got=%h exp=11", SrcA); end
    step();
    mem_reg_write = 1'b0; wb_reg_write = 1'b1; wb_rd = 5'd3; wb_result = 32'h11;
    #1;
    checks++; if (SrcA !== 32'h11) begin errors++; $display("FAIL hold_wb got=%h exp=11", SrcA); end
    step();
    wb_reg_write = 1'b0;
    #1;
    checks++; if (SrcA !== 32'h11) begin errors++; $display("FAIL hold_retired got=%h exp=11", SrcA); end
    idle();
  endtask
`endif

  task automatic test_async_reset();
    drive(4'h5, 5'd1, 5'd2, 5'd3, 1'b1, 32'h9, 32'h9, 32'd0, 32'd0, 1'b0, 1'b0);
    dec_if.in_valid = 1'b1; ex_ready = 1'b0;
    step();
    dec_if.in_valid = 1'b0;
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b exp=1", ex_valid); end
    rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || ex_reg_write !== 1'b0 || ex_rd !== 5'd0) begin errors++; $display("FAIL arst_ctl got=%b/%b/%h exp=0/0/0", ex_valid, ex_reg_write, ex_rd); end
    checks++; if (SrcA !== 32'd0 || SrcB !== 32'd0 || ALUControl !== 4'h0) begin errors++; $display("FAIL arst_ops got=%h/%h/%h exp=0/0/0", SrcA, SrcB, ALUControl); end
    step();
    rst_n = 1'b1;
    idle();
  endtask

  initial begin
    test_reset();
    test_basic_add();
    test_mux();
    test_back_to_back();
    test_stall();
    test_flush();
`ifndef IDEX_FORWARD_EN
    test_hazard_stall();
`else
    test_forward();
    test_fwd_hold();
`endif
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
